// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Master indices, also used as bit positions in the grant vector
  localparam int MST_I = 0;
  localparam int MST_D = 1;

  // Default bus widths: line address and full cache line
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;

  // Maps a round-robin pick onto the grant state it leads to
  function automatic arb_state_t grantState(input logic pickD);
    return pickD ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_arb_rr_picker.sv
// Two-way round-robin pick between the I-cache and D-cache requests.
// A lone requester always wins; a tie goes to whichever side the
// priority bit currently favours.
module mem_arb_rr_picker (
  input  logic i_reqI,
  input  logic i_reqD,
  input  logic i_prioD,
  output logic o_pickD,
  output logic o_valid
);

  assign o_valid = i_reqI | i_reqD;
  assign o_pickD = i_reqD & (~i_reqI | i_prioD);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave Wishbone-style arbiter placed between the split
// I-cache / D-cache controllers and the single physical-memory port.
// Grants are registered; address, data and control are muxed
// combinationally from the granted master, so a held grant adds no latency.
// A RELEASE cycle after every transaction keeps m_cyc low between owners.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_cyc,
  input  logic              i_stb,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_rty,

  input  logic              d_cyc,
  input  logic              d_stb,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_rty,

  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  input  logic              m_rty,

  output logic [1:0]        grant
);

  arb_state_t r_state;
  arb_state_t w_nextState;
  logic       r_prioD;
  logic       w_nextPrioD;
  logic       w_reqI;
  logic       w_reqD;
  logic       w_pickD;
  logic       w_pickValid;

  assign w_reqI = i_cyc & i_stb;
  assign w_reqD = d_cyc & d_stb;

  // Read data fans out to both masters; only the ack qualifies it
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  mem_arb_rr_picker u_picker (
    .i_reqI  (w_reqI),
    .i_reqD  (w_reqD),
    .i_prioD (r_prioD),
    .o_pickD (w_pickD),
    .o_valid (w_pickValid)
  );

  // State and round-robin priority registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_prioD <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_prioD <= w_nextPrioD;
    end
  end

  // Next-state and priority update; a completed transfer hands priority to
  // the other master, an abort leaves it alone, a retry holds the grant
  always_comb begin
    w_nextState = r_state;
    w_nextPrioD = r_prioD;
    case (r_state)
      IDLE: begin
        if (w_pickValid) begin
          w_nextState = grantState(w_pickD);
        end
      end
      GNT_I: begin
        if (m_ack) begin
          w_nextState = RELEASE;
          w_nextPrioD = 1'b1;
        end else if (!i_cyc) begin
          w_nextState = RELEASE;
        end
      end
      GNT_D: begin
        if (m_ack) begin
          w_nextState = RELEASE;
          w_nextPrioD = 1'b0;
        end else if (!d_cyc) begin
          w_nextState = RELEASE;
        end
      end
      RELEASE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output mux: the granted master drives the memory port and sees its
  // ack/retry; everything is quiet in IDLE and RELEASE
  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    i_ack   = 1'b0;
    i_rty   = 1'b0;
    d_ack   = 1'b0;
    d_rty   = 1'b0;
    grant   = 2'b00;
    case (r_state)
      GNT_I: begin
        m_cyc        = i_cyc;
        m_stb        = i_stb;
        m_we         = i_we;
        m_addr       = i_addr;
        m_wdata      = i_wdata;
        i_ack        = m_ack;
        i_rty        = m_rty;
        grant[MST_I] = 1'b1;
      end
      GNT_D: begin
        m_cyc        = d_cyc;
        m_stb        = d_stb;
        m_we         = d_we;
        m_addr       = d_addr;
        m_wdata      = d_wdata;
        d_ack        = m_ack;
        d_rty        = m_rty;
        grant[MST_D] = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
